// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the
// boot loader, bundled together so the loader and its environment share one
// connection point.
//   master : the loader side (consumes bytes, drives the memory write port)
//   slave  : the environment side (byte source plus instruction memory)
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader. Parses a stream of
//   N[7:0], N[15:8], 4*N data bytes (little-endian words), XOR checksum byte
// writes each assembled word to instruction memory at byte address 4*index,
// and releases the CPU (cpu_run) only after a clean load with a good checksum.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,         // asynchronous, active-low
    imem_loader_if.master bus,
    output logic          cpu_run,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_LOAD,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;     // header word count N
    logic [1:0]  lane_q,  lane_d;      // byte lane of the word being assembled
    logic [31:0] word_q,  word_d;      // word under assembly
    logic [7:0]  csum_q,  csum_d;      // running XOR of data bytes
    logic [15:0] words_q, words_d;     // words written so far

    logic        accept;
    logic [15:0] hdr_n;

    assign accept = bus.rx_valid && bus.rx_ready;
    assign hdr_n  = {bus.rx_data, count_q[7:0]};

    // State register: abort to the initial header state whenever reset is low.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HDR0;
            count_q <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            words_q <= words_d;
        end
    end

    // Next-state logic: header parse, byte-lane assembly, write, checksum check.
    always_comb begin
        // NOTE: every variable gets its hold value first, so paths that do not
        // assign it cannot infer a latch.
        state_d = state_q;
        count_d = count_q;
        lane_d  = lane_q;
        word_d  = word_q;
        csum_d  = csum_q;
        words_d = words_q;

        unique case (state_q)
            S_HDR0: begin
                if (accept) begin
                    count_d[7:0] = bus.rx_data;
                    state_d      = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    count_d[15:8] = bus.rx_data;
                    if (hdr_n > 16'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    word_d[{lane_q, 3'b000} +: 8] = bus.rx_data;
                    csum_d = csum_q ^ bus.rx_data;
                    // Lane wraps 3 -> 0 as the completed word goes to WRITE.
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + 16'd1;
                state_d = (words_d == count_q) ? S_CSUM : S_LOAD;
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_HDR0;
        endcase
    end

    // Outputs decoded from the registered state; rx_ready is also held low
    // while reset is asserted so no byte is taken during reset.
    always_comb begin
        bus.rx_ready = reset && ((state_q == S_HDR0) || (state_q == S_HDR1) ||
                                 (state_q == S_LOAD) || (state_q == S_CSUM));
        bus.imem_we    = (state_q == S_WRITE);
        bus.imem_addr  = {14'd0, words_q, 2'b00};
        bus.imem_wdata = word_q;
        done           = (state_q == S_DONE);
        err            = (state_q == S_ERR);
        cpu_run        = (state_q == S_DONE);
        busy           = (state_q == S_HDR1) || (state_q == S_LOAD) ||
                         (state_q == S_WRITE) || (state_q == S_CSUM);
        words_loaded   = words_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed streams from the test plan
// plus randomized loads, checked against a word-level model of the stream.
module tb_imem_loader;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_run, busy, done, err;
    logic [15:0] words_loaded;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  stream[$];     // bytes to send
    logic [31:0] exp_words[$];  // words the stream carries
    logic [31:0] cap_addr[$];   // observed memory writes
    logic [31:0] cap_data[$];
    logic [31:0] tb_mem[DEPTH];
    int          we_bad = 0;    // write pulses overlapping rx_ready or lasting >1 cycle
    logic        prev_we = 1'b0;

    // Monitor: record every memory write, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            cap_addr.push_back(bus.imem_addr);
            cap_data.push_back(bus.imem_wdata);
            if (bus.imem_addr < 32'(4 * DEPTH)) tb_mem[bus.imem_addr[31:2]] = bus.imem_wdata;
            if (bus.rx_ready !== 1'b0 || prev_we) we_bad++;
        end
        prev_we = (bus.imem_we === 1'b1);
    end

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        cap_addr = {};
        cap_data = {};
        we_bad   = 0;
    endtask

    // Build a stream from exp_words; a bad checksum is corrupted by a nonzero XOR.
    task automatic build_stream(input int n, input bit good);
        logic [7:0]  x;
        logic [15:0] n16;
        n16 = 16'(n);
        x = 8'h00;
        stream = {};
        stream.push_back(n16[7:0]);
        stream.push_back(n16[15:8]);
        foreach (exp_words[i]) begin
            for (int b = 0; b < 4; b++) begin
                stream.push_back(8'((exp_words[i] >> (8 * b)) & 32'hFF));
                x = x ^ 8'((exp_words[i] >> (8 * b)) & 32'hFF);
            end
        end
        stream.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    // Offer one byte after 'gap' idle cycles; return once it has been taken.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        logic acc;
        bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            acc = bus.rx_ready;
            @(posedge clk);
            #1;
            if (acc === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte timeout: byte %02h never accepted (rx_ready %b, want 1)", b, bus.rx_ready);
        end
    endtask

    // gap_mode < 0 picks a random gap of 0..2 idle cycles before each byte.
    task automatic send_stream(input int gap_mode, input int limit);
        bit ok;
        for (int i = 0; i < stream.size() && i < limit; i++) begin
            send_byte(stream[i], (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode, ok);
            if (!ok) break;
        end
        bus.rx_valid = 1'b0;
    endtask

    // Scenario: send the current stream and compare against the model outcome.
    task automatic run_load(input string name, input int n, input bit good, input int gap_mode);
        int  exp_w;
        bit  exp_ok;
        exp_w  = (n > DEPTH) ? 0 : n;
        exp_ok = (n <= DEPTH) && good;
        send_stream(gap_mode, stream.size());
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cap_data.size() != exp_w) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d want %0d", name, cap_data.size(), exp_w);
        end
        for (int i = 0; i < exp_w && i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_addr[i] !== 32'(4 * i) || cap_data[i] !== exp_words[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got %08h@%08h want %08h@%08h",
                         name, i, cap_data[i], cap_addr[i], exp_words[i], 32'(4 * i));
            end
        end
        n_checks++;
        if (words_loaded !== 16'(exp_w)) begin
            n_fail++;
            $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, exp_w);
        end
        n_checks++;
        if ({done, cpu_run, err, busy, bus.rx_ready} !== {exp_ok, exp_ok, !exp_ok, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s status {done,cpu_run,err,busy,rx_ready}: got %b want %b", name,
                     {done, cpu_run, err, busy, bus.rx_ready}, {exp_ok, exp_ok, !exp_ok, 1'b0, 1'b0});
        end
        n_checks++;
        if (we_bad != 0) begin
            n_fail++;
            $display("FAIL %s we_pulse: got %0d bad write cycles want 0", name, we_bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h02;
        #3;
        n_checks++;
        if ({bus.rx_ready, bus.imem_we, cpu_run, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset flags {rx_ready,we,cpu_run,busy,done,err}: got %b want 000000",
                     {bus.rx_ready, bus.imem_we, cpu_run, busy, done, err});
        end
        n_checks++;
        if (bus.imem_addr !== 32'd0 || bus.imem_wdata !== 32'd0 || words_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL reset values addr/wdata/words: got %h/%h/%0d want 0/0/0",
                     bus.imem_addr, bus.imem_wdata, words_loaded);
        end
        do_reset();
        n_checks++;
        if (bus.rx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset release rx_ready/busy: got %b/%b want 1/0", bus.rx_ready, busy);
        end
    endtask

    task automatic test_two_word();
        do_reset();
        stream    = {8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h10};
        exp_words = {32'h00500113, 32'h00C00193};
        run_load("two_word", 2, 1'b1, 0);
    endtask

    task automatic test_bad_csum();
        int writes;
        do_reset();
        stream    = {8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h11};
        exp_words = {32'h00500113, 32'h00C00193};
        run_load("bad_csum", 2, 1'b0, 0);
        writes = cap_data.size();
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rx_data = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (bus.rx_ready !== 1'b0 || err !== 1'b1 || cpu_run !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_csum sticky {rx_ready,err,cpu_run}: got %b want 010",
                         {bus.rx_ready, err, cpu_run});
            end
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        n_checks++;
        if (cap_data.size() != writes || words_loaded !== 16'd2) begin
            n_fail++;
            $display("FAIL bad_csum extra_bytes: got %0d writes, words %0d want %0d, 2",
                     cap_data.size(), words_loaded, writes);
        end
    endtask

    task automatic test_oversize();
        bit ok;
        logic [7:0] hi[2];
        logic [7:0] lo[2];
        lo[0] = 8'h41; hi[0] = 8'h00;   // N = 65, one past capacity
        lo[1] = 8'h00; hi[1] = 8'h01;   // N = 256, only the high byte set
        for (int t = 0; t < 2; t++) begin
            do_reset();
            send_byte(lo[t], 0, ok);
            n_checks++;
            if (busy !== 1'b1 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL oversize[%0d] after_hdr0 busy/err: got %b/%b want 1/0", t, busy, err);
            end
            send_byte(hi[t], 0, ok);
            bus.rx_valid = 1'b0;
            n_checks++;
            if ({err, busy, done, cpu_run, bus.rx_ready} !== 5'b10000) begin
                n_fail++;
                $display("FAIL oversize[%0d] status {err,busy,done,cpu_run,rx_ready}: got %b want 10000",
                         t, {err, busy, done, cpu_run, bus.rx_ready});
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'hAA;
            repeat (6) @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
            n_checks++;
            if (cap_data.size() != 0 || bus.rx_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL oversize[%0d] no_write: got %0d writes rx_ready %b want 0 writes rx_ready 0",
                         t, cap_data.size(), bus.rx_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tb_mem[0] = 32'h0;
        tb_mem[1] = 32'h0;
        stream    = {8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h10};
        exp_words = {32'h00500113, 32'h00C00193};
        run_load("backpressure", 2, 1'b1, 1);
        n_checks++;
        if (tb_mem[0] !== 32'h00500113 || tb_mem[1] !== 32'h00C00193) begin
            n_fail++;
            $display("FAIL backpressure memory: got %08h %08h want 00500113 00C00193", tb_mem[0], tb_mem[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tb_mem[0] = 32'h0;
        stream    = {8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h10};
        exp_words = {32'h00500113, 32'h00C00193};
        send_stream(0, 7);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.rx_ready, bus.imem_we, cpu_run, busy, done, err} !== 6'b0 ||
            bus.imem_addr !== 32'd0 || bus.imem_wdata !== 32'd0 || words_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid abort: flags %b addr %h wdata %h words %0d want all zero",
                     {bus.rx_ready, bus.imem_we, cpu_run, busy, done, err},
                     bus.imem_addr, bus.imem_wdata, words_loaded);
        end
        n_checks++;
        if (tb_mem[0] !== 32'h00500113) begin
            n_fail++;
            $display("FAIL reset_mid first_word_written: got %08h want 00500113", tb_mem[0]);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        cap_addr = {};
        cap_data = {};
        we_bad   = 0;
        run_load("reset_mid_rerun", 2, 1'b1, 0);
    endtask

    task automatic test_empty();
        do_reset();
        stream    = {8'h00, 8'h00, 8'h00};
        exp_words = {};
        run_load("empty", 0, 1'b1, 0);
    endtask

    task automatic test_random();
        int  n;
        bit  good;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            n    = int'($urandom_range(1, 10));
            good = ($urandom_range(0, 2) != 0);
            exp_words = {};
            for (int i = 0; i < n; i++) exp_words.push_back($urandom);
            build_stream(n, good);
            run_load($sformatf("random[%0d]", it), n, good, -1);
        end
    endtask

    task automatic test_max_depth();
        do_reset();
        exp_words = {};
        for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom);
        build_stream(DEPTH, 1'b1);
        run_load("max_depth", DEPTH, 1'b1, -1);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_two_word();
        test_bad_csum();
        test_oversize();
        test_backpressure();
        test_reset_mid();
        test_empty();
        test_random();
        test_max_depth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
